// File: rtl/multu_hilo_unit.sv
// Unsigned shift-add multiplier with HI/LO commit, driven by the ALU-control function-code stream.
// MULTU starts a WIDTH-iteration multiply, HILO_WR commits it, and MFHI/MFLO read the committed registers.
module multu_hilo_unit #(
  parameter int         WIDTH        = 32,
  parameter logic [5:0] MULTU_CODE   = 6'b011001,
  parameter logic [5:0] HILO_WR_CODE = 6'b111111,
  parameter logic [5:0] MFHI_CODE    = 6'b010000,
  parameter logic [5:0] MFLO_CODE    = 6'b010010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic             hilo_wr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi, lo;
  logic [CW-1:0]      cnt;
  logic               wr_pend;
  logic               armed;
  logic               is_mult, is_wr;
  logic [WIDTH:0]     upper;
  logic [2*WIDTH-1:0] prod_nxt;

  assign is_mult = (Signal == MULTU_CODE);
  assign is_wr   = (Signal == HILO_WR_CODE);

  // One shift-add step; the carry out of the upper half shifts down into bit 2W-1.
  assign upper    = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : '0);
  assign prod_nxt = {upper, product[WIDTH-1:1]};

  always_comb begin
    dataOut = '0;
    if (Signal == MFHI_CODE)      dataOut = hi;
    else if (Signal == MFLO_CODE) dataOut = lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      product <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      wr_pend <= 1'b0;
      armed   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      hilo_wr <= 1'b0;
    end else begin
      hilo_wr <= 1'b0;
      // A MULTU code held past completion must not retrigger; any other code re-arms.
      if (!is_mult) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (is_mult && armed) begin
            mcand   <= dataA;
            product <= {{WIDTH{1'b0}}, dataB};
            cnt     <= '0;
            wr_pend <= 1'b0;
            armed   <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!is_mult && !is_wr) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            product <= prod_nxt;
            cnt     <= cnt + 1'b1;
            if (is_wr) wr_pend <= 1'b1;
            if (cnt == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (is_wr || wr_pend) begin
            hi      <= product[2*WIDTH-1:WIDTH];
            lo      <= product[WIDTH-1:0];
            hilo_wr <= 1'b1;
            wr_pend <= 1'b0;
            done    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: commit timing, early commit, abort, held MULTU, async reset.
module tb_multu_hilo_unit;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] HWR   = 6'b111111;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] NOP   = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  Signal;
  logic [31:0] dataA, dataB, dataOut;
  logic        busy, done, hilo_wr;
  int          total = 0;
  int          bad = 0;
  int          pulses;

  multu_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Signal(Signal), .dataA(dataA), .dataB(dataB),
    .dataOut(dataOut), .busy(busy), .done(done), .hilo_wr(hilo_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive a code, let one rising edge take it, sample 1ns later.
  task automatic step(input logic [5:0] s);
    Signal = s;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [5:0] s, input string tag, input logic [31:0] exp);
    Signal = s;
    #1;
    chk(tag, dataOut, exp);
  endtask

  initial begin
    rst_n = 1'b0; Signal = MFHI; dataA = '0; dataB = '0;
    #13;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo_wr", hilo_wr, 0);
    chk("rst_dataout", dataOut, 0);
    Signal = NOP;
    rst_n = 1'b1;
    step(NOP);

    // 1) 7*6, MULTU held 33 edges then HILO_WR
    dataA = 32'd7; dataB = 32'd6;
    step(MULTU);
    chk("t1_busy_start", busy, 1);
    for (int i = 2; i <= 32; i++) step(MULTU);
    chk("t1_busy_e32", busy, 1);
    chk("t1_done_e32", done, 0);
    step(MULTU);
    chk("t1_done_e33", done, 1);
    chk("t1_busy_e33", busy, 0);
    rd(MFLO, "t1_lo_before_commit", 32'd0);
    step(HWR);
    chk("t1_hilo_wr", hilo_wr, 1);
    chk("t1_done_clr", done, 0);
    rd(MFLO, "t1_lo", 32'd42);
    rd(MFHI, "t1_hi", 32'd0);
    step(NOP);
    chk("t1_pulse_1cyc", hilo_wr, 0);

    // 2) max * max
    dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF;
    for (int i = 1; i <= 33; i++) step(MULTU);
    chk("t2_done", done, 1);
    step(HWR);
    chk("t2_hilo_wr", hilo_wr, 1);
    rd(MFHI, "t2_hi", 32'hFFFF_FFFE);
    rd(MFLO, "t2_lo", 32'h0000_0001);
    step(NOP);

    // 3) early commit: HILO_WR lands on the last iteration edge
    dataA = 32'h0001_0000; dataB = 32'h0001_0000;
    for (int i = 1; i <= 32; i++) step(MULTU);
    chk("t3_busy_e32", busy, 1);
    step(HWR);
    chk("t3_done_e33", done, 1);
    chk("t3_hilo_wr_e33", hilo_wr, 0);
    step(NOP);
    chk("t3_hilo_wr", hilo_wr, 1);
    chk("t3_done_1cyc", done, 0);
    rd(MFHI, "t3_hi", 32'd1);
    rd(MFLO, "t3_lo", 32'd0);
    step(NOP);

    // 4) abort at iteration 10
    dataA = 32'd5; dataB = 32'd5;
    for (int i = 1; i <= 10; i++) step(MULTU);
    chk("t4_busy_pre", busy, 1);
    step(ADD);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_hilo_wr", hilo_wr, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(NOP);
      if (hilo_wr || done) pulses++;
    end
    chk("t4_no_complete", pulses, 0);
    rd(MFHI, "t4_hi_kept", 32'd1);
    rd(MFLO, "t4_lo_kept", 32'd0);

    // 5) MULTU held 80 edges: exactly one multiply, no commit
    dataA = 32'd3; dataB = 32'd4;
    pulses = 0;
    for (int i = 1; i <= 80; i++) begin
      step(MULTU);
      if (hilo_wr) pulses++;
      if (i == 32) chk("t5_busy_e32", busy, 1);
      if (i == 33) chk("t5_busy_e33", busy, 0);
      if (i == 40) dataA = 32'd100;
    end
    chk("t5_busy_e80", busy, 0);
    chk("t5_done_e80", done, 1);
    chk("t5_no_pulse", pulses, 0);
    step(HWR);
    chk("t5_hilo_wr", hilo_wr, 1);
    rd(MFLO, "t5_lo", 32'd12);
    step(NOP);

    // 6) async reset mid-RUN, then clean restart
    dataA = 32'd9; dataB = 32'd9;
    for (int i = 1; i <= 10; i++) step(MULTU);
    Signal = MFLO;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_lo_clr", dataOut, 0);
    Signal = NOP;
    #1 rst_n = 1'b1;
    step(NOP);
    for (int i = 1; i <= 33; i++) step(MULTU);
    chk("t6_done_restart", done, 1);
    step(HWR);
    chk("t6_hilo_wr", hilo_wr, 1);
    rd(MFLO, "t6_lo", 32'd81);
    rd(MFHI, "t6_hi", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
